// File: rtl/symbol_vector_pkg.sv
// Shared types and width helpers for the symbol_vector storage engine.
package symbol_vector_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INS_SHIFT = 2'd1,
        REM_SHIFT = 2'd2
    } state_t;

    // Width of an element index; never below one bit.
    function automatic int index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // Width of an element count, which must also hold the full capacity.
    function automatic int length_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/symbol_vector.sv
// Fixed-capacity ordered element store with positional insert/remove/get.
// Build option SYMBOL_VECTOR_CLEAR_EN zeroes vacated slots and clears the array on reset.
module symbol_vector
    import symbol_vector_pkg::*;
#(
    parameter int  DATA_WIDTH = 7,
    parameter int  DATA_COUNT = 127,
    localparam int IW = index_width(DATA_COUNT),
    localparam int LW = length_width(DATA_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IW-1:0]         index,
    input  logic                  get,
    input  logic                  insert,
    input  logic                  remove,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LW-1:0]         length,
    output logic                  ready
);

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DATA_COUNT];
    logic [IW-1:0]         p;
    logic [IW-1:0]         i_q;
    logic [DATA_WIDTH-1:0] d_q;

    logic [LW-1:0]         index_ext;
    logic                  in_range;
    logic                  can_insert;
    logic                  rem_more;
    logic                  mem_we;
    logic [IW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign index_ext  = LW'(index);
    assign in_range   = index_ext < length;
    assign can_insert = (length != LW'(DATA_COUNT)) && (index_ext <= length);
    // p < length-1, written so it cannot underflow
    assign rem_more   = (LW'(p) + LW'(1)) < length;
    assign ready      = (state == IDLE);

    // One array write per cycle: a shift step, the final insert, or an optional clear.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (state)
            INS_SHIFT: begin
                mem_we = 1'b1;
                if (p > i_q) begin
                    mem_waddr = p;
                    mem_wdata = mem[p - IW'(1)];
                end else begin
                    mem_waddr = i_q;
                    mem_wdata = d_q;
                end
            end
            REM_SHIFT: begin
                if (rem_more) begin
                    mem_we    = 1'b1;
                    mem_waddr = p;
                    mem_wdata = mem[p + IW'(1)];
                end
`ifdef SYMBOL_VECTOR_CLEAR_EN
                else begin
                    mem_we    = 1'b1;
                    mem_waddr = IW'(length - LW'(1));
                end
`endif
            end
            default: ;
        endcase
    end

`ifdef SYMBOL_VECTOR_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DATA_COUNT; k++) mem[k] <= '0;
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            length   <= '0;
            data_out <= '0;
            p        <= '0;
            i_q      <= '0;
            d_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (insert && can_insert) begin
                        i_q   <= index;
                        d_q   <= data_in;
                        p     <= IW'(length);
                        state <= INS_SHIFT;
                    end else if (remove && in_range) begin
                        p     <= index;
                        state <= REM_SHIFT;
                    end else if (get) begin
                        data_out <= in_range ? mem[index] : '0;
                    end
                end
                INS_SHIFT: begin
                    if (p > i_q) begin
                        p <= p - IW'(1);
                    end else begin
                        length <= length + LW'(1);
                        state  <= IDLE;
                    end
                end
                REM_SHIFT: begin
                    if (rem_more) begin
                        p <= p + IW'(1);
                    end else begin
                        length <= length - LW'(1);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_symbol_vector.sv
// Bench for symbol_vector: queue-based reference model, random fill/edit, timing and reset checks.
module tb_symbol_vector;

    localparam int DW = 7;
    localparam int DC = 127;
    localparam int IW = 7;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] index = '0;
    logic          get = 1'b0;
    logic          insert = 1'b0;
    logic          remove = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic [LW-1:0] length;
    logic          ready;

    int errors = 0;
    int checks = 0;

    // Reference contents, element 0 first.
    logic [DW-1:0] exp_q[$];

    symbol_vector dut (
        .clk(clk), .rst(rst), .index(index), .get(get), .insert(insert),
        .remove(remove), .data_in(data_in), .data_out(data_out),
        .length(length), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Called at a negedge; returns how many further negedges saw ready low.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 1000) begin
            cycles++;
            @(negedge clk);
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic do_insert(input string tag, input int idx, input logic [DW-1:0] val);
        int busy, exp_busy;
        bit ok;
        ok       = (exp_q.size() != DC) && (idx <= exp_q.size());
        exp_busy = ok ? exp_q.size() - idx + 1 : 0;
        index    = IW'(idx);
        data_in  = val;
        insert   = 1'b1;
        @(negedge clk);
        insert = 1'b0;
        wait_ready(busy);
        if (ok) exp_q.insert(idx, val);
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        check({tag, "_len"}, 32'(length), 32'(exp_q.size()));
    endtask

    task automatic do_remove(input string tag, input int idx);
        int busy, exp_busy;
        bit ok;
        ok       = idx < exp_q.size();
        exp_busy = ok ? exp_q.size() - idx : 0;
        index    = IW'(idx);
        remove   = 1'b1;
        @(negedge clk);
        remove = 1'b0;
        wait_ready(busy);
        if (ok) exp_q.delete(idx);
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        check({tag, "_len"}, 32'(length), 32'(exp_q.size()));
    endtask

    task automatic do_get(input string tag, input int idx);
        logic [DW-1:0] exp_v;
        exp_v = (idx < exp_q.size()) ? exp_q[idx] : '0;
        index = IW'(idx);
        get   = 1'b1;
        @(negedge clk);
        get = 1'b0;
        check(tag, 32'(data_out), 32'(exp_v));
    endtask

    task automatic get_all(input string tag);
        for (int k = 0; k < exp_q.size(); k++) do_get(tag, k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int busy;
        logic [DW-1:0] first_v;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_len", 32'(length), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        do_get("rst_get0", 0);

        // Small hand-built sequence
        do_insert("ins_a", 0, 7'h61);
        do_insert("ins_c", 1, 7'h63);
        do_insert("ins_b", 1, 7'h62);
        do_get("abc_get0", 0);
        do_get("abc_get1", 1);
        do_get("abc_get2", 2);
        do_get("abc_get3", 3);
        do_remove("rem0", 0);
        do_get("bc_get0", 0);
        do_get("bc_get1", 1);
        do_get("bc_get2", 2);

        // Out-of-range requests are ignored without a ready gap
        do_insert("ins_oor", 5, 7'h11);
        do_remove("rem_oor", 2);

        // Random fill to capacity
        while (exp_q.size() < DC)
            do_insert("fill", $urandom_range(0, exp_q.size()), DW'($urandom_range(0, 127)));
        get_all("full_get");
        do_get("full_get_top", 127);
        do_insert("ins_full", $urandom_range(0, DC), 7'h55);
        check("full_ready", 32'(ready), 32'd1);

        // Random mixed edits
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1 || exp_q.size() == DC)
                do_remove("mix_rem", $urandom_range(0, exp_q.size()));
            else
                do_insert("mix_ins", $urandom_range(0, exp_q.size() + 1), DW'($urandom_range(0, 127)));
        end
        get_all("mix_get");
        do_remove("rem_last", exp_q.size() - 1);
        do_get("after_rem_last", exp_q.size());

        // Remove on empty vector
        do_reset();
        do_remove("rem_empty", 5);
        check("rem_empty_ready", 32'(ready), 32'd1);

        // Insert pulsed again while busy must be ignored
        for (int n = 0; n < 10; n++) do_insert("pre", n, DW'($urandom_range(0, 127)));
        first_v = DW'($urandom_range(0, 127));
        index   = '0;
        data_in = first_v;
        insert  = 1'b1;
        @(negedge clk);
        check("busy_ready_low", 32'(ready), 32'd0);
        data_in = ~first_v;
        @(negedge clk);
        insert = 1'b0;
        wait_ready(busy);
        exp_q.insert(0, first_v);
        check("busy_ins_busy", 32'(busy + 1), 32'(exp_q.size()));
        check("busy_ins_len", 32'(length), 32'(exp_q.size()));
        get_all("busy_get");

        // Reset in the middle of a shift
        index   = '0;
        data_in = 7'h7e;
        insert  = 1'b1;
        @(negedge clk);
        insert = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_len", 32'(length), 32'd0);
        check("midrst_dout", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        do_get("midrst_get0", 0);
        do_insert("ins_41", 0, 7'h41);
        do_get("get_41", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
